// File: rtl/jit_cf_pkg.sv
// Shared definitions for the JIT control-flow solver.
// Holds the branch/tail increments, the solver state encoding and the
// forward datapath f(a,b) = (a+b) + (a==b ? EQ_INC : NE_INC) + TAIL_INC.
// The forward function works on 32-bit zero-extended operands; callers
// truncate to their own width, which gives the mod 2^WIDTH result for any
// WIDTH up to 32.
package jit_cf_pkg;

   localparam int EQ_INC   = 1;
   localparam int NE_INC   = 2;
   localparam int TAIL_INC = 4;   // four chained +1 stages in the forward path

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Forward datapath; the equality test must see the zero-extended operands.
   function automatic logic [31:0] cf_forward(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] sum_s;
      logic [31:0] br_s;
      sum_s = a + b;
      if (a == b) begin
         br_s = sum_s + 32'(EQ_INC);
      end else begin
         br_s = sum_s + 32'(NE_INC);
      end
      return br_s + 32'(TAIL_INC);
   endfunction

endpackage

// File: rtl/jit_control_flow_solver_if.sv
// Request/result stream bundle for jit_control_flow_solver.
// Request side : in_valid/in_ready handshake carrying in_a and in_target.
// Result side  : out_valid/out_ready handshake carrying out_found, out_b,
//                out_count.
// master = requester/consumer, slave = solver.
interface jit_control_flow_solver_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_target;
   logic             out_valid;
   logic             out_ready;
   logic             out_found;
   logic [WIDTH-1:0] out_b;
   logic [1:0]       out_count;

   modport master (
      output in_valid, in_a, in_target, out_ready,
      input  in_ready, out_valid, out_found, out_b, out_count
   );

   modport slave (
      input  in_valid, in_a, in_target, out_ready,
      output in_ready, out_valid, out_found, out_b, out_count
   );
endinterface

// File: rtl/jit_cf_eval.sv
// Combinational evaluator of the forward control-flow datapath.
// Ports: a, b (WIDTH operands) -> f (WIDTH result, mod 2^WIDTH).
// WIDTH must not exceed 32.
module jit_cf_eval
   import jit_cf_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f
);

   assign f = WIDTH'(cf_forward(32'(a), 32'(b)));

endmodule

// File: rtl/jit_control_flow_solver.sv
// Sequential inverse of the forward control-flow datapath.
// Accepts (a, target), tries every b from 0 to 2^WIDTH-1 one per cycle and
// reports the smallest matching b plus a saturating match count.
// Ports: clk, rst (synchronous, active high), bus (slave side of
// jit_control_flow_solver_if). All bus outputs come straight from flops.
module jit_control_flow_solver
   import jit_cf_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   jit_control_flow_solver_if.slave      bus
);

   state_t           state_r, state_s;
   logic [WIDTH-1:0] cnt_r, cnt_s;
   logic [WIDTH-1:0] a_r, a_s;
   logic [WIDTH-1:0] target_r, target_s;
   logic             found_r, found_s;
   logic [WIDTH-1:0] first_b_r, first_b_s;
   logic [1:0]       count_r, count_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] f_s;

   jit_cf_eval #(.WIDTH(WIDTH)) u_eval (
      .a (a_r),
      .b (cnt_r),
      .f (f_s)
   );

   // Next-state and datapath updates for the IDLE/SCAN/DONE sequence.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      a_s       = a_r;
      target_s  = target_r;
      found_s   = found_r;
      first_b_s = first_b_r;
      count_s   = count_r;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               a_s       = bus.in_a;
               target_s  = bus.in_target;
               cnt_s     = {WIDTH{1'b0}};
               found_s   = 1'b0;
               first_b_s = {WIDTH{1'b0}};
               count_s   = 2'd0;
               state_s   = SCAN;
            end else begin
               state_s   = IDLE;
            end
         end
         SCAN: begin
            if (f_s == target_r) begin
               if (count_r != 2'd3) begin
                  count_s = count_r + 2'd1;
               end else begin
                  count_s = count_r;
               end
               // Only the first hit records b, so first_b is the smallest match.
               if (!found_r) begin
                  found_s   = 1'b1;
                  first_b_s = cnt_r;
               end else begin
                  found_s   = found_r;
               end
            end else begin
               count_s = count_r;
            end
            // Stop on the last candidate instead of letting the counter wrap.
            if (cnt_r == {WIDTH{1'b1}}) begin
               state_s = DONE;
            end else begin
               cnt_s   = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and handshake flags; the flags are decoded from the next state
   // so they line up with the state register without a combinational output.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= {WIDTH{1'b0}};
         a_r         <= {WIDTH{1'b0}};
         target_r    <= {WIDTH{1'b0}};
         found_r     <= 1'b0;
         first_b_r   <= {WIDTH{1'b0}};
         count_r     <= 2'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         cnt_r       <= cnt_s;
         a_r         <= a_s;
         target_r    <= target_s;
         found_r     <= found_s;
         first_b_r   <= first_b_s;
         count_r     <= count_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == DONE);
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_found = found_r;
   assign bus.out_b     = first_b_r;
   assign bus.out_count = count_r;

endmodule
